// File: rtl/pixel_plot_fifo_pkg.sv
// Shared types and constants for the pixel plot FIFO: pixel record, screen
// bounds, output colour palette and frame-tracking FSM states.
package plot_pkg;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;

  // Gray-code ramp so adjacent iteration bands differ in one colour bit
  localparam logic [2:0] PALETTE [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fifo_state_t;

  function automatic logic coord_in_range(input logic [7:0] x, input logic [6:0] y);
    return (x < SCREEN_W) && (y < SCREEN_H);
  endfunction

endpackage

// File: rtl/pixel_plot_fifo_ram.sv
// Pixel storage for the plot FIFO: synchronous write, asynchronous read,
// contents deliberately left unreset.
module pixel_fifo_ram
  import plot_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  pixel_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output pixel_t                   rdata
);

  pixel_t mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pixel_plot_fifo.sv
// First-word-fall-through pixel FIFO between the Mandelbrot generator and the
// VGA adapter, with frame-done tracking and sticky drop/out-of-range flags.
// Optional build macro PIXEL_PLOT_PALETTE_EN remaps out_colour through PALETTE.
module pixel_plot_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_x,
  input  logic [6:0]             in_y,
  input  logic [2:0]             in_colour,
  input  logic                   in_plot,
  input  logic                   in_done,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             out_x,
  output logic [6:0]             out_y,
  output logic [2:0]             out_colour,
  output logic                   out_plot,
  input  logic                   out_ready,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   bad_coord
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             almost_full_q, almost_full_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             bad_coord_q, bad_coord_d;
  logic             frame_done_q, frame_done_d;
  fifo_state_t      state_q, state_d;

  logic   in_range_s;
  logic   push_s;
  logic   pop_s;
  pixel_t wr_pix_s;
  pixel_t rd_pix_s;

  // Handshake decode, pointer/occupancy next state and sticky error flags
  always_comb begin
    in_range_s = coord_in_range(in_x, in_y);
    pop_s      = valid_q & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle
    push_s     = in_plot & in_range_s & (~full_q | pop_s);

    wr_pix_s.x      = in_x;
    wr_pix_s.y      = in_y;
    wr_pix_s.colour = in_colour;

    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d        = (count_d == CNT_FULL);
    almost_full_d = (count_d >= CNT_AF);
    valid_d       = (count_d != CNT_ZERO);

    // Out-of-range pixels never reach the overflow check
    overflow_d  = overflow_q | (in_plot & in_range_s & full_q & ~pop_s);
    bad_coord_d = bad_coord_q | (in_plot & ~in_range_s);
  end

  // Frame-tracking FSM next state and registered frame_done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (push_s) begin
          state_d = RUN;
        end else if (in_done) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (in_done && (count_q == CNT_ZERO) && !push_s) begin
          state_d = DONE;
        end else if (in_done) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if ((count_q == CNT_ZERO) && !push_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (!in_done) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    frame_done_d = (state_d == DONE);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= CNT_ZERO;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      valid_q       <= 1'b0;
      overflow_q    <= 1'b0;
      bad_coord_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      state_q       <= IDLE;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      valid_q       <= valid_d;
      overflow_q    <= overflow_d;
      bad_coord_q   <= bad_coord_d;
      frame_done_q  <= frame_done_d;
      state_q       <= state_d;
    end
  end

  pixel_fifo_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (push_s),
    .waddr(wr_ptr_q),
    .wdata(wr_pix_s),
    .raddr(rd_ptr_q),
    .rdata(rd_pix_s)
  );

  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign count       = count_q;
  assign out_plot    = valid_q;
  assign out_x       = rd_pix_s.x;
  assign out_y       = rd_pix_s.y;
`ifdef PIXEL_PLOT_PALETTE_EN
  assign out_colour  = PALETTE[rd_pix_s.colour];
`else
  assign out_colour  = rd_pix_s.colour;
`endif
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign bad_coord   = bad_coord_q;

endmodule
